// File: rtl/button_request_conditioner_pkg.sv
// Shared constants for the button request conditioner: channel count and
// the default debounce window derived from the board clock.
package button_request_conditioner_pkg;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int unsigned DEBOUNCE_MS = 10;
    localparam int unsigned N_CH        = 4;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage : button_request_conditioner_pkg

// File: rtl/button_request_conditioner_debounce_channel.sv
// One input channel: 2-flop synchroniser, stability counter, debounced level
// and a registered one-cycle press pulse; exports next level and rise.
module debounce_channel
    import button_request_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press_pulse,
    output logic level_nxt_c,
    output logic rise_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    // Accept a new level only after sync2 has differed for DEBOUNCE_CYCLES edges.
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        pulse_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign level       = stable_q;
    assign press_pulse = pulse_q;
    assign level_nxt_c = stable_d;
    assign rise_c      = pulse_d;

endmodule : debounce_channel

// File: rtl/button_request_conditioner.sv
// Debounced request lines for the downstream 4-to-2 priority encoder, with
// an optional sticky mode that holds presses until cleared.
module button_request_conditioner #(
    parameter int unsigned N_CH            = button_request_conditioner_pkg::N_CH,
    parameter int unsigned DEBOUNCE_CYCLES = button_request_conditioner_pkg::DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_raw,
    input  logic            mode_sticky,
    input  logic [N_CH-1:0] clr,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] req
);

    logic [N_CH-1:0] level_nxt_c;
    logic [N_CH-1:0] rise_c;
    logic [N_CH-1:0] req_q, req_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .btn_raw    (btn_raw[g]),
            .level      (level[g]),
            .press_pulse(press_pulse[g]),
            .level_nxt_c(level_nxt_c[g]),
            .rise_c     (rise_c[g])
        );
    end

    // Sticky: set beats clear so a press landing on a clear is never lost.
    always_comb begin
        req_d = req_q;
        if (mode_sticky) begin
            req_d = (req_q & ~clr) | rise_c;
        end else begin
            req_d = level_nxt_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else begin
            req_q <= req_d;
        end
    end

    assign req = req_q;

endmodule : button_request_conditioner

// File: tb/tb_button_request_conditioner.sv
// Directed bench for button_request_conditioner with DEBOUNCE_CYCLES = 4.
module tb_button_request_conditioner;

    localparam int unsigned NC = 4;
    localparam int unsigned DC = 4;

    logic          clk;
    logic          rst_n;
    logic [NC-1:0] btn_raw;
    logic          mode_sticky;
    logic [NC-1:0] clr;
    logic [NC-1:0] level;
    logic [NC-1:0] press_pulse;
    logic [NC-1:0] req;

    int total = 0;
    int bad   = 0;
    int stepno = 0;

    typedef struct {
        logic [3:0] btn;
        logic       sticky;
        logic [3:0] clr;
        logic [3:0] lvl;
        logic [3:0] pls;
        logic [3:0] req;
    } vec_t;

    vec_t tbl[$];

    button_request_conditioner #(
        .N_CH           (NC),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .mode_sticky(mode_sticky),
        .clr        (clr),
        .level      (level),
        .press_pulse(press_pulse),
        .req        (req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%b want=%b", nm, stepno, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] b, input logic s, input logic [3:0] c);
        btn_raw     = b;
        mode_sticky = s;
        clr         = c;
        @(posedge clk);
        #1;
        stepno++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(4'b0000, 1'b1, 4'b0000);
        step(4'b0000, 1'b1, 4'b0000);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [3:0] b, input logic s, input logic [3:0] c,
                                input logic [3:0] l, input logic [3:0] p, input logic [3:0] r);
        vec_t v;
        v.btn = b; v.sticky = s; v.clr = c; v.lvl = l; v.pls = p; v.req = r;
        return v;
    endfunction

    // Downstream priority encoder view of req: highest set index wins.
    function automatic logic [1:0] enc_y(input logic [3:0] d);
        logic [1:0] y;
        y = 2'b00;
        for (int i = 0; i < 4; i++) if (d[i]) y = 2'(i);
        return y;
    endfunction

    initial begin
        int pcount;
        int pstep;
        logic [3:0] b;
        logic [3:0] c;

        rst_n       = 1'b1;
        btn_raw     = '0;
        mode_sticky = 1'b1;
        clr         = '0;
        #2;

        // Reset with all buttons held, then release: held buttons count as new presses.
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) step(4'b1111, 1'b1, 4'b0000);
        chk("rst_level", level, 4'b0000);
        chk("rst_pulse", press_pulse, 4'b0000);
        chk("rst_req", req, 4'b0000);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step(4'b1111, 1'b1, 4'b0000);
            chk("rel_level", level, (k >= 6) ? 4'b1111 : 4'b0000);
            chk("rel_pulse", press_pulse, (k == 6) ? 4'b1111 : 4'b0000);
            chk("rel_req", req, (k >= 6) ? 4'b1111 : 4'b0000);
        end

        // Table: sticky ch2 press/release/clear, then non-sticky and mode switches.
        for (int k = 0; k < 5; k++) tbl.push_back(mk(4'b0100, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0100, 1, 4'b0000, 4'b0100, 4'b0100, 4'b0100));
        tbl.push_back(mk(4'b0100, 1, 4'b0000, 4'b0100, 4'b0000, 4'b0100));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b0100, 4'b0000, 4'b0100));
        tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0100));
        tbl.push_back(mk(4'b0000, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(4'b1010, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b1010, 0, 4'b0000, 4'b1010, 4'b1010, 4'b1010));
        tbl.push_back(mk(4'b1010, 0, 4'b0000, 4'b1010, 4'b0000, 4'b1010));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b1010, 4'b0000, 4'b1010));
        tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1010));
        tbl.push_back(mk(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(4'b1010, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b1010, 0, 4'b0000, 4'b1010, 4'b1010, 4'b1010));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(4'b0000, 0, 4'b1111, 4'b1010, 4'b0000, 4'b1010));
        tbl.push_back(mk(4'b0000, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].btn, tbl[i].sticky, tbl[i].clr);
            chk("tbl_level", level, tbl[i].lvl);
            chk("tbl_pulse", press_pulse, tbl[i].pls);
            chk("tbl_req", req, tbl[i].req);
            if (tbl[i].req == 4'b1010 && tbl[i].pls == 4'b1010) begin
                chk("enc_y", {2'b00, enc_y(req)}, 4'b0011);
                chk("enc_v", {3'b000, |req}, 4'b0001);
            end
        end

        // Glitch: three sync2 cycles high is one short of acceptance.
        do_reset();
        for (int k = 0; k < 13; k++) begin
            b = (k < 3) ? 4'b0001 : 4'b0000;
            step(b, 1'b1, 4'b0000);
            chk("glitch_level", level, 4'b0000);
            chk("glitch_pulse", press_pulse, 4'b0000);
            chk("glitch_req", req, 4'b0000);
        end

        // Bounce on ch1: toggles every 2 cycles, final rise at step 20.
        do_reset();
        pcount = 0;
        pstep  = -1;
        for (int k = 0; k < 45; k++) begin
            if (k < 20) b = (((k / 2) % 2) == 0) ? 4'b0010 : 4'b0000;
            else        b = 4'b0010;
            step(b, 1'b1, 4'b0000);
            if (press_pulse[1]) begin
                pcount++;
                pstep = k;
            end
        end
        chk_int("bounce_pulse_count", pcount, 1);
        chk_int("bounce_pulse_step", pstep, 20 + DC + 1);
        chk("bounce_level", level, 4'b0010);
        chk("bounce_req", req, 4'b0010);

        // Set/clear collision on ch3: clear on the accepting edge loses to the set.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            c = (k == 5) ? 4'b1000 : 4'b0000;
            step(4'b1000, 1'b1, c);
            chk("coll_req", req, (k >= 5) ? 4'b1000 : 4'b0000);
            chk("coll_pulse", press_pulse, (k == 5) ? 4'b1000 : 4'b0000);
        end
        step(4'b1000, 1'b1, 4'b0100);
        chk("clr_idle_req", req, 4'b1000);
        step(4'b1000, 1'b1, 4'b1000);
        chk("clr_ch3_req", req, 4'b0000);
        chk("clr_ch3_level", level, 4'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule : tb_button_request_conditioner
